// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the fetch unit (read-only) and the
//   data/stack unit (read/write). One access is in flight at a time. The
//   arbiter latches the address (and write data) when it grants an access. It
//   then holds memory read or write high for ACCESS_CYCLES cycles, captures
//   read data at the end of the strobe, and pulses the winner's ack for one
//   cycle.
//
// Handshake (both ports): req is a level held by the requester until its ack.
//   The request and its operands are sampled only while the arbiter is idle.
//   ack is a single-cycle pulse that marks completion. For a read, the port's
//   rdata is valid from the ack cycle and holds until that port's next read
//   completes. A req that is still high in the idle cycle after an ack counts
//   as a new request. Dropping req after the grant does not cancel the access.
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   f_req/f_addr       fetch request and address
//   f_rdata/f_ack      fetch read data and completion pulse
//   d_req/d_we         data request, 1 = write
//   d_addr/d_wdata     data address and write data
//   d_rdata/d_ack      data read result and completion pulse
//   mem_read/mem_write memory strobes (never both high)
//   mem_addr/mem_wdata memory address / write data, stable under a strobe
//   mem_rdata          memory read data
//   busy               high whenever the arbiter is not idle
//   state_dbg          current FSM state (IDLE=0, ACCESS=1, DONE=2)
module mem_port_arbiter #(
  parameter int ADDR_W        = 5,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_data;  // 1: the previous grant went to the data port
  logic             cur_data;   // the access in flight belongs to the data port
  logic             cur_we;     // the access in flight is a write
  logic             grant_f;
  logic             grant_d;

  // Next state and grant decision
  always_comb begin
    state_nxt = state;
    grant_f   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        // On a tie, the port that did not win last time gets the grant.
        if (f_req && d_req) begin
          if (last_data) grant_f = 1'b1;
          else           grant_d = 1'b1;
        end else if (f_req) begin
          grant_f = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end
        if (grant_f || grant_d) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath: latch operands on grant, count down, capture read data.
  // A reset here aborts any access in flight with no ack. It also sends the
  // tie-break back to favouring the data port.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      last_data <= 1'b0;
      cur_data  <= 1'b0;
      cur_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      f_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      if (grant_f || grant_d) begin
        mem_addr  <= grant_d ? d_addr : f_addr;
        cur_data  <= grant_d;
        cur_we    <= grant_d & d_we;
        last_data <= grant_d;
        cnt       <= CNT_LOAD;
        if (grant_d && d_we) mem_wdata <= d_wdata;
      end
      if (state == ACCESS) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else if (!cur_we) begin
          // Sample at the end of the last strobe cycle, so the memory has
          // had the full strobe window to drive its data.
          if (cur_data) d_rdata <= mem_rdata;
          else          f_rdata <= mem_rdata;
        end
      end
    end
  end

  // Outputs are decoded from registered state, so they change cleanly after
  // the clock edge. Both are zero while idle.
  assign mem_read  = (state == ACCESS) && !cur_we;
  assign mem_write = (state == ACCESS) &&  cur_we;
  assign f_ack     = (state == DONE) && !cur_data;
  assign d_ack     = (state == DONE) &&  cur_data;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule
